// File: rtl/itype_instr_gen_pkg.sv
// itype_instr_gen_pkg: shared constants and FSM state type for the OP-IMM instruction generator.
package itype_instr_gen_pkg;

    localparam logic [6:0]  OP_IMM        = 7'b0010011;
    localparam logic [31:0] NOP_WORD      = 32'h00000013;
    localparam logic [2:0]  F3_SLLI       = 3'd1;
    localparam logic [2:0]  F3_SRLI_SRAI  = 3'd5;
    localparam logic [11:0] SLLI_IMM_MASK = 12'h01F;
    localparam logic [11:0] SRXI_IMM_MASK = 12'h41F;
    localparam logic [31:0] LFSR_TAPS     = 32'h80200003;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

endpackage

// File: rtl/itype_instr_gen_lfsr32.sv
// itype_lfsr32: 32-bit Galois LFSR with step enable and seed reload; a zero seed becomes 1.
module itype_lfsr32
    import itype_instr_gen_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h000003DD
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        step_i,
    input  logic        load_i,
    output logic [31:0] state_o,
    output logic [31:0] next_o
);

    localparam logic [31:0] INIT = (SEED == 32'd0) ? 32'd1 : SEED;

    logic [31:0] state_q;

    assign state_o = state_q;
    assign next_o  = {1'b0, state_q[31:1]} ^ (state_q[0] ? LFSR_TAPS : 32'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= INIT;
        else if (load_i)
            state_q <= INIT;
        else if (step_i)
            state_q <= next_o;
    end

endmodule

// File: rtl/itype_instr_gen.sv
// itype_instr_gen: streams random legal RV32I OP-IMM instructions over a valid/ready handshake.
// Define ITYPE_NO_X0_DEST_EN to remap x0 destinations to x1.
module itype_instr_gen
    import itype_instr_gen_pkg::*;
#(
    parameter logic [31:0] SEED      = 32'h000003DD,
    parameter logic [15:0] NUM_INSTR = 16'd100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic        busy,
    output logic        done,
    output logic [15:0] issued_cnt
);

    localparam logic [15:0] LAST_CNT = NUM_INSTR - 16'd1;

    state_e      state_q;
    logic        valid_q, busy_q, done_q, stop_pend_q;
    logic [31:0] instr_q;
    logic [15:0] cnt_q;
    logic [31:0] lfsr_q, lfsr_next;
    logic        fire, last, finish, launch;

    function automatic logic [31:0] map_instr(input logic [31:0] l);
        logic [11:0] imm;
        logic [4:0]  rd;
        imm = (l[14:12] == F3_SRLI_SRAI) ? (l[31:20] & SRXI_IMM_MASK) :
              (l[14:12] == F3_SLLI)      ? (l[31:20] & SLLI_IMM_MASK) : l[31:20];
`ifdef ITYPE_NO_X0_DEST_EN
        rd = (l[11:7] == 5'd0) ? 5'd1 : l[11:7];
`else
        rd = l[11:7];
`endif
        return {imm, l[19:15], l[14:12], rd, OP_IMM};
    endfunction

    itype_lfsr32 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .step_i  (fire),
        .load_i  (1'b0),
        .state_o (lfsr_q),
        .next_o  (lfsr_next)
    );

    assign fire   = valid_q && instr_ready;
    assign last   = (NUM_INSTR != 16'd0) && (cnt_q == LAST_CNT);
    // A stop only ends the run on a handshake so the held word is never dropped.
    assign finish = fire && (last || stop || stop_pend_q);
    assign launch = start && !stop && (state_q != S_RUN);

    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign issued_cnt  = cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            instr_q     <= NOP_WORD;
            cnt_q       <= 16'd0;
        end else if (launch) begin
            state_q     <= S_RUN;
            valid_q     <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            instr_q     <= map_instr(lfsr_q);
            cnt_q       <= 16'd0;
        end else if (state_q == S_RUN) begin
            if (fire)
                cnt_q <= cnt_q + 16'd1;
            if (finish) begin
                state_q     <= S_DONE;
                valid_q     <= 1'b0;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
                stop_pend_q <= 1'b0;
                instr_q     <= NOP_WORD;
            end else begin
                if (fire)
                    instr_q <= map_instr(lfsr_next);
                if (stop)
                    stop_pend_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_itype_instr_gen.sv
// tb_itype_instr_gen: three generator instances checked against a cycle model built from the field/LFSR rules.
module tb_itype_instr_gen;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st[3], sp[3], rdy[3], v[3], b[3], d[3];
    logic [31:0] w[3];
    logic [15:0] c[3];

    always #5 clk = ~clk;

    itype_instr_gen #(.SEED(32'h12345678), .NUM_INSTR(16'd4)) u_a (
        .clk(clk), .reset_n(rst_n), .start(st[0]), .stop(sp[0]), .instr_ready(rdy[0]),
        .instr_valid(v[0]), .instr(w[0]), .busy(b[0]), .done(d[0]), .issued_cnt(c[0]));
    itype_instr_gen #(.SEED(32'h00001000), .NUM_INSTR(16'd0)) u_b (
        .clk(clk), .reset_n(rst_n), .start(st[1]), .stop(sp[1]), .instr_ready(rdy[1]),
        .instr_valid(v[1]), .instr(w[1]), .busy(b[1]), .done(d[1]), .issued_cnt(c[1]));
    itype_instr_gen #(.SEED(32'h00000000)) u_c (
        .clk(clk), .reset_n(rst_n), .start(st[2]), .stop(sp[2]), .instr_ready(rdy[2]),
        .instr_valid(v[2]), .instr(w[2]), .busy(b[2]), .done(d[2]), .issued_cnt(c[2]));

    int errs = 0;
    int checks = 0;
    int obs_fires[3];

    int          m_st[3];
    logic [31:0] m_l[3];
    logic [15:0] m_cnt[3];
    bit          m_pend[3];
    logic [31:0] m_seed[3];
    int unsigned m_num[3];

    typedef struct {
        logic        rdy;
        logic        exp_v;
        logic [15:0] exp_c;
        logic        exp_d;
    } vec_t;
    vec_t tbl[12];
    logic [31:0] first_exp[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic logic [31:0] encode(input logic [31:0] l);
        int unsigned imm = l[31:20];
        int unsigned rs1 = l[19:15];
        int unsigned f3  = l[14:12];
        int unsigned rd  = l[11:7];
        if (f3 == 5) imm = imm & 32'h41F;
        else if (f3 == 1) imm = imm & 32'h1F;
`ifdef ITYPE_NO_X0_DEST_EN
        if (rd == 0) rd = 1;
`endif
        return imm * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12) + rd * (1 << 7) + 32'h13;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_st[k]   = 0;
            m_l[k]    = (m_seed[k] == 0) ? 32'd1 : m_seed[k];
            m_cnt[k]  = 16'd0;
            m_pend[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        bit fire, fin;
        fire = (m_st[k] == 1) && rdy[k];
        if (m_st[k] == 1) begin
            fin = fire && ((m_num[k] != 0 && m_cnt[k] == m_num[k] - 1) || sp[k] || m_pend[k]);
            if (fire) begin
                m_cnt[k] = m_cnt[k] + 16'd1;
                m_l[k]   = lfsr_next(m_l[k]);
            end
            if (fin) begin
                m_st[k]   = 2;
                m_pend[k] = 1'b0;
            end else if (sp[k])
                m_pend[k] = 1'b1;
        end else if (rst_n && st[k] && !sp[k]) begin
            m_st[k]   = 1;
            m_cnt[k]  = 16'd0;
            m_pend[k] = 1'b0;
        end
    endtask

    task automatic compare(input int k);
        bit run = (m_st[k] == 1);
        chk($sformatf("u%0d.valid", k), v[k], run);
        chk($sformatf("u%0d.instr", k), w[k], run ? encode(m_l[k]) : NOP);
        chk($sformatf("u%0d.busy", k), b[k], run);
        chk($sformatf("u%0d.done", k), d[k], m_st[k] == 2);
        chk($sformatf("u%0d.cnt", k), c[k], m_cnt[k]);
    endtask

    task automatic cyc();
        for (int k = 0; k < 3; k++)
            if (v[k] && rdy[k]) obs_fires[k]++;
        @(posedge clk);
        if (rst_n)
            for (int k = 0; k < 3; k++) model_step(k);
        #1;
        for (int k = 0; k < 3; k++) compare(k);
    endtask

    initial begin
        m_seed = '{32'h12345678, 32'h00001000, 32'h00000000};
        m_num  = '{4, 0, 100};
`ifdef ITYPE_NO_X0_DEST_EN
        first_exp = '{32'h00345613, 32'h00001093, 32'h00000093};
`else
        first_exp = '{32'h00345613, 32'h00001013, 32'h00000013};
`endif
        tbl[0]  = '{1'b1, 1'b1, 16'd1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 16'd1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 16'd1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 16'd2, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 16'd2, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 16'd2, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 16'd3, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 16'd3, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 16'd3, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 16'd4, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 16'd4, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 16'd4, 1'b1};
        for (int k = 0; k < 3; k++) begin
            st[k] = 1'b0; sp[k] = 1'b0; rdy[k] = 1'b0; obs_fires[k] = 0;
        end
        model_reset();
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();

        // first instruction appears one cycle after start
        for (int k = 0; k < 3; k++) st[k] = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            st[k] = 1'b0;
            chk($sformatf("u%0d.first_instr", k), w[k], first_exp[k]);
        end

        // bounded run with stalls on u_a
        obs_fires[0] = 0;
        for (int i = 0; i < 12; i++) begin
            rdy[0] = tbl[i].rdy;
            cyc();
            chk($sformatf("tbl%0d.valid", i), v[0], tbl[i].exp_v);
            chk($sformatf("tbl%0d.cnt", i), c[0], tbl[i].exp_c);
            chk($sformatf("tbl%0d.done", i), d[0], tbl[i].exp_d);
        end
        rdy[0] = 1'b0;
        chk("u0.fires_exact", obs_fires[0], 4);
        chk("u0.nop_after", w[0], NOP);

        // stop while stalled on unbounded u_b
        sp[1] = 1'b1; cyc(); sp[1] = 1'b0;
        chk("stop_hold.valid", v[1], 1'b1);
        chk("stop_hold.done", d[1], 1'b0);
        cyc();
        rdy[1] = 1'b1; cyc(); rdy[1] = 1'b0;
        chk("stop_fire.done", d[1], 1'b1);
        chk("stop_fire.cnt", c[1], 16'd1);
        chk("stop_fire.valid", v[1], 1'b0);

        // start+stop in DONE is ignored, then restart and stop on a fire
        st[1] = 1'b1; sp[1] = 1'b1; cyc(); st[1] = 1'b0; sp[1] = 1'b0;
        chk("startstop_done.done", d[1], 1'b1);
        chk("startstop_done.busy", b[1], 1'b0);
        st[1] = 1'b1; cyc(); st[1] = 1'b0;
        chk("restart.busy", b[1], 1'b1);
        chk("restart.cnt", c[1], 16'd0);
        rdy[1] = 1'b1; sp[1] = 1'b1; cyc(); rdy[1] = 1'b0; sp[1] = 1'b0;
        chk("stop_with_fire.cnt", c[1], 16'd1);
        chk("stop_with_fire.done", d[1], 1'b1);

        // start while RUN does not clear the count
        rdy[2] = 1'b1; cyc();
        st[2] = 1'b1; cyc(); st[2] = 1'b0; rdy[2] = 1'b0;
        chk("start_in_run.cnt", c[2], 16'd2);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            for (int k = 0; k < 3; k++) begin
                rdy[k] = 1'($urandom_range(0, 1));
                st[k]  = ($urandom_range(0, 15) == 0);
                sp[k]  = ($urandom_range(0, 39) == 0);
            end
            cyc();
        end
        for (int k = 0; k < 3; k++) begin
            st[k] = 1'b0; sp[k] = 1'b0; rdy[k] = 1'b0;
        end

        // put u_a mid-run, then reset asynchronously
        sp[0] = 1'b1; cyc(); sp[0] = 1'b0;
        rdy[0] = 1'b1; cyc(); rdy[0] = 1'b0;
        st[0] = 1'b1; cyc(); st[0] = 1'b0;
        rdy[0] = 1'b1; cyc(); rdy[0] = 1'b0;
        chk("pre_reset.busy", b[0], 1'b1);
        #3 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("async_rst%0d.valid", k), v[k], 1'b0);
            chk($sformatf("async_rst%0d.instr", k), w[k], NOP);
            chk($sformatf("async_rst%0d.busy", k), b[k], 1'b0);
            chk($sformatf("async_rst%0d.done", k), d[k], 1'b0);
            chk($sformatf("async_rst%0d.cnt", k), c[k], 16'd0);
        end
        model_reset();
        cyc();
        rst_n = 1'b1;
        cyc();
        st[0] = 1'b1; sp[0] = 1'b1; cyc(); st[0] = 1'b0; sp[0] = 1'b0;
        chk("startstop_idle.busy", b[0], 1'b0);
        chk("startstop_idle.done", d[0], 1'b0);
        st[0] = 1'b1; cyc(); st[0] = 1'b0;
        chk("replay.first_instr", w[0], 32'h00345613);
        rdy[0] = 1'b1; repeat (6) cyc(); rdy[0] = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/itype_instr_gen.md
ITYPE_INSTR_GEN -- requirements
Module: itype_instr_gen

Interface
REQ-001 Parameter SEED, default 32'h000003DD, initial LFSR state (0 is replaced by 32'h00000001).
REQ-002 Parameter NUM_INSTR, default 16'd100, instructions per run (0 = unbounded).
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse, begins a run.
REQ-006 stop  in  1  one-cycle pulse, ends a run early.
REQ-007 instr_ready  in  1  consumer (core imem response side) accepts instr this cycle.
REQ-008 instr_valid  out  1  instr holds a generated instruction.
REQ-009 instr  out  32  RV32I OP-IMM instruction word; 32'h00000013 (NOP) whenever instr_valid=0.
REQ-010 busy  out  1  high in RUN.
REQ-011 done  out  1  high in DONE.
REQ-012 issued_cnt  out  16  accepted instructions in current run.

Function
REQ-013 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on last handshake or stop; DONE->RUN on start; DONE->IDLE never (only reset).
REQ-014 Handshake fire = instr_valid && instr_ready; instr and instr_valid registered, stable while valid && !ready.
REQ-015 Latency: instr_valid rises the cycle after start is sampled; back-to-back fires sustain 1 instruction/cycle.
REQ-016 32-bit Galois LFSR, taps 32'h80200003, advances by one step only on fire.
REQ-017 Field map from current LFSR state L: imm=L[31:20], rs1=L[19:15], funct3=L[14:12], rd=L[11:7], opcode=7'b0010011.
REQ-018 funct3==3'd5: imm &= 12'h41F (legal SRLI/SRAI); funct3==3'd1: imm &= 12'h01F (legal SLLI); others unmodified.
REQ-019 issued_cnt increments on fire; cleared on start; wraps 16'hFFFF->0 when NUM_INSTR=0.
REQ-020 Run completes when fire occurs with issued_cnt==NUM_INSTR-1 (NUM_INSTR!=0); instr_valid drops next cycle.
REQ-021 stop with pending unaccepted instruction: instruction stays valid until fire, then DONE; no instruction dropped or truncated.
REQ-022 stop and fire same cycle: that fire counts, then DONE.
REQ-023 start and stop same cycle: stop wins; state unchanged (IDLE stays IDLE, DONE stays DONE).
REQ-024 start while RUN: ignored.
REQ-025 Restart from DONE continues the LFSR sequence (no reseed).

Reset
REQ-026 reset_n low, any state, immediately: state=IDLE, LFSR=SEED (or 1), instr_valid=0, instr=32'h00000013, busy=0, done=0, issued_cnt=0.
REQ-027 Reset mid-run abandons the pending instruction; no fire is reported.

Configuration
REQ-028 Macro ITYPE_NO_X0_DEST_EN defined: generated rd==0 replaced by rd=5'd1, so every instruction writes a visible register.
REQ-029 Macro absent: rd taken unmodified from L[11:7]; x0 destinations allowed.

Structure
REQ-030 Shared package holds OP_IMM opcode constant, NOP word 32'h00000013, funct3 constants (SLLI=1, SRLI_SRAI=5), shift-imm masks, FSM state enum.
REQ-031 One sub-module itype_lfsr32 (step enable, seed load, state out); field mapping and constraints stay in the top.

Verification
REQ-032 SEED=32'h12345678, start, ready=1 -> first instr=32'h00345613 (funct3=5, imm masked to 12'h003, rs1=8, rd=12) one cycle after start.
REQ-033 SEED=32'h00001000 -> first instr=32'h00001013; with ITYPE_NO_X0_DEST_EN -> 32'h00001093.
REQ-034 SEED=0 -> first instr=32'h00000013 (LFSR=1); with ITYPE_NO_X0_DEST_EN -> 32'h00000093.
REQ-035 NUM_INSTR=4, ready toggling 1,0,0,1,... -> instr stable across stalls, exactly 4 fires, issued_cnt=4, done=1, instr_valid=0 and instr=NOP after.
REQ-036 NUM_INSTR=0, stop asserted while valid && !ready -> held instr accepted on next ready, then done=1 with issued_cnt counting that fire.
REQ-037 reset_n pulsed low mid-run -> all outputs at reset values in the same cycle; new start replays the SEED sequence from its first instruction.
